// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction-fetch front end.
// Owns the PC and the single-outstanding instruction-memory handshake and
// presents the instruction, its PC+4 and a flush strobe to the IF/ID register.
// Outputs are combinational from state and inputs (zero added latency).
//
// Ports:
//   clk_i           clock, all state updates on posedge
//   rst_i           synchronous active-high reset
//   hazard_i        stall from hazard unit (IF/ID holds while high)
//   branch_i        taken branch/jump redirect pulse from ID
//   branch_target_i redirect address (bits [1:0] ignored)
//   imem_req_o      memory request level
//   imem_addr_o     request address, stable while a request is pending
//   imem_ack_i      one-cycle data-valid pulse (may coincide with request)
//   imem_data_i     instruction word, valid with imem_ack_i
//   inst_o          instruction to IF/ID (0 when not valid)
//   pc_add_4_o      PC+4 of inst_o (0 when not valid)
//   valid_o         inst_o holds a real instruction
//   flush_o         flush strobe to IF/ID
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_add_4_o,
  output logic        valid_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_inst_q;
  logic [31:0] redir_pc_q;

  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = {branch_target_i[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      hold_inst_q <= '0;
      redir_pc_q  <= '0;
    end else begin
      case (state_q)
        REQ: begin
          if (branch_i) begin
            if (imem_ack_i) begin
              pc_q <= target;
            end else begin
              redir_pc_q <= target;
              state_q    <= DROP;
            end
          end else if (imem_ack_i) begin
            if (hazard_i) begin
              hold_inst_q <= imem_data_i;
              state_q     <= HOLD;
            end else begin
              pc_q <= pc_plus4;
            end
          end
        end
        HOLD: begin
          if (branch_i) begin
            pc_q    <= target;
            state_q <= REQ;
          end else if (!hazard_i) begin
            pc_q    <= pc_plus4;
            state_q <= REQ;
          end
        end
        DROP: begin
          // The pending request must complete before redirecting; the
          // latest branch seen while waiting wins.
          if (imem_ack_i) begin
            pc_q    <= branch_i ? target : redir_pc_q;
            state_q <= REQ;
          end else if (branch_i) begin
            redir_pc_q <= target;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    inst_o      = '0;
    pc_add_4_o  = '0;
    valid_o     = 1'b0;
    flush_o     = 1'b0;
    if (!rst_i) begin
      flush_o = branch_i;
      case (state_q)
        REQ: begin
          imem_req_o = 1'b1;
          if (!branch_i && imem_ack_i) begin
            valid_o    = 1'b1;
            inst_o     = imem_data_i;
            pc_add_4_o = pc_plus4;
          end
        end
        HOLD: begin
          if (!branch_i) begin
            valid_o    = 1'b1;
            inst_o     = hold_inst_q;
            pc_add_4_o = pc_plus4;
          end
        end
        DROP: begin
          imem_req_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end. Owns the PC and the instruction-memory request/ack handshake.
- Drives the values that the IF/ID pipeline register captures: instruction, PC+4, and the flush strobe.
- Obeys the stall from the hazard detection unit and the branch/jump redirect from ID.
- Delivers an NOP bubble (all zeros) whenever no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset. Bits [1:0] must be 0.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  synchronous, active-high reset.
- hazard_i  input  1  stall from hazard unit; IF/ID holds its contents while high.
- branch_i  input  1  taken branch/jump redirect from ID, one-cycle pulse.
- branch_target_i  input  32  redirect address. Bits [1:0] are ignored and treated as 0.
- imem_req_o  output  1  instruction memory request, level.
- imem_addr_o  output  32  request address; stable while imem_req_o is high.
- imem_ack_i  input  1  one-cycle data-valid pulse; may arrive in the same cycle as the request.
- imem_data_i  input  32  instruction word, valid when imem_ack_i is high.
- inst_o  output  32  instruction to IF/ID.
- pc_add_4_o  output  32  PC+4 of inst_o, to IF/ID.
- valid_o  output  1  inst_o holds a real instruction.
- flush_o  output  1  flush strobe to IF/ID.

Behaviour:
- Registers:
  - pc (32 bits)
  - state in {REQ, HOLD, DROP}
  - hold_inst (32 bits)
  - redir_pc (32 bits)
- Reset (rst_i high at posedge): pc=RESET_PC, state=REQ, hold_inst=0, redir_pc=0.
- While rst_i is high, outputs are forced: imem_req_o=0, valid_o=0, inst_o=0, flush_o=0.
- The memory model shares rst_i, so no ack from a pre-reset request ever arrives after reset.
- Outputs are combinational from state/inputs, giving zero added latency; IF/ID supplies the pipeline register.
- When valid_o=0: inst_o=0 and pc_add_4_o=0.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- REQ state:
  - Drives imem_req_o=1, imem_addr_o=pc.
  - branch_i=1 (highest priority): flush_o=1, valid_o=0.
    - If imem_ack_i=1: data discarded, pc<=target, stay REQ.
    - If imem_ack_i=0: redir_pc<=target, go DROP.
  - else imem_ack_i=1 and hazard_i=0: valid_o=1, inst_o=imem_data_i, pc_add_4_o=pc+4; pc<=pc+4, stay REQ.
  - else imem_ack_i=1 and hazard_i=1: hold_inst<=imem_data_i, go HOLD. valid_o=1 is shown, but IF/ID ignores it because it is stalled.
  - else (no ack): valid_o=0; stay REQ with the address unchanged.
- HOLD state:
  - imem_req_o=0, valid_o=1, inst_o=hold_inst, pc_add_4_o=pc+4.
  - branch_i=1: flush_o=1, valid_o=0, pc<=target, go REQ. The held word is discarded.
  - else hazard_i=0: IF/ID captures this cycle; pc<=pc+4, go REQ.
  - else stay HOLD.
- DROP state (redirect pending behind an outstanding request):
  - imem_req_o=1, imem_addr_o=pc (old address, held stable), valid_o=0.
  - branch_i=1: flush_o=1, redir_pc<=new target (latest branch wins).
  - imem_ack_i=1: data discarded, pc<=redir_pc (or the new target if branch_i=1 in the same cycle), go REQ.
- Handshake rules:
  - imem_addr_o never changes while imem_req_o=1 and no ack has been received.
  - At most one request is outstanding at a time.
  - imem_req_o is deasserted only in HOLD and during reset.
- hazard_i has no effect in DROP and no effect on a cycle with branch_i=1.
- flush_o is high exactly in the cycles where branch_i=1 and rst_i=0.

Test Plan:
- Reset, then zero-wait memory (ack same cycle) returning addr^32'hA5A5_0000 → imem_addr_o=0,4,8,C on consecutive cycles; inst_o matches; pc_add_4_o=4,8,C,10; valid_o=1 every cycle.
- 2-cycle-latency memory → each address is held 2 cycles; valid_o=0 with inst_o=0 on the wait cycle; then valid_o=1 with the correct word; no address change mid-request.
- hazard_i=1 for 3 cycles starting on the ack of addr 0x8 (data 0x1234_5678) → state HOLD; imem_req_o=0; inst_o=0x1234_5678 and pc_add_4_o=0xC for 4 cycles; next request addr=0xC.
- 3-cycle memory, branch_i=1 with target 0x43 in the first wait cycle of request 0x10 → flush_o=1 for 1 cycle; addr stays 0x10 until ack; that data is dropped (valid_o=0); next request addr=0x40.
- In HOLD, branch_i=1 and hazard_i=1 in the same cycle with target 0x100 → flush_o=1, hold discarded, next request addr=0x100. In DROP, a second branch to 0x200 → final redirect goes to 0x200.
- RESET_PC=0xFFFF_FFF8 with zero-wait memory → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_add_4_o=0 for FFFF_FFFC. Assert rst_i mid-HOLD → next cycle addr=RESET_PC, valid_o=0.
